// File: rtl/b2a_pkg.sv
// Shared types and helpers for the boolean share splitter.
package b2a_pkg;

    // Controller states: waiting for a word, drawing randomness, presenting shares.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Width of the share counter: ceil(log2(nShares)), never less than one bit.
    function automatic int cntWidth(input int nShares);
        int w;
        w = 1;
        while ((1 << w) < nShares) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lix_xor.sv
// Word-wide XOR used to fold each fresh random word into the running accumulator.
module lix_xor #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);

    assign o_y = i_a ^ i_b;

endmodule

// File: rtl/bool_share_split.sv
// Splits one unmasked word into N_SHARES boolean shares whose XOR is the word.
// Shares 0..N-2 are raw random words; the last share is the word XOR all of them.
module bool_share_split
    import b2a_pkg::*;
#(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          i_vld,
    output logic                          i_rdy,
    input  logic [K_WIDTH-1:0]            i_x,
    input  logic                          rnd_vld,
    output logic                          rnd_rdy,
    input  logic [K_WIDTH-1:0]            rnd,
    output logic                          o_vld,
    input  logic                          o_rdy,
    output logic [K_WIDTH*N_SHARES-1:0]   o_z,
    output logic                          busy
);

    localparam int CNT_W = cntWidth(N_SHARES);
    // Index of the last random share; the transfer at this count also closes the word.
    localparam logic [CNT_W-1:0] CNT_LAST = (N_SHARES >= 2) ? CNT_W'(N_SHARES - 2) : '0;

    state_t                             r_state;
    logic [CNT_W-1:0]                   r_cnt;
    logic [K_WIDTH-1:0]                 r_acc;
    logic [N_SHARES-1:0][K_WIDTH-1:0]   r_share;

    logic                               w_inXfer;
    logic                               w_rndXfer;
    logic                               w_outXfer;
    logic [K_WIDTH-1:0]                 w_accXorRnd;

    // Ready/valid are decoded from state alone so no vld input loops back to a rdy.
    assign i_rdy   = (r_state == IDLE);
    assign rnd_rdy = (r_state == FILL);
    assign o_vld   = (r_state == OUT);
    assign busy    = (r_state != IDLE);

    // Shares are only exposed while presenting, so partial state never leaks out.
    assign o_z = (r_state == OUT) ? r_share : '0;

    assign w_inXfer  = i_vld   & i_rdy   & ena;
    assign w_rndXfer = rnd_vld & rnd_rdy & ena;
    assign w_outXfer = o_vld   & o_rdy   & ena;

    lix_xor #(
        .W   (K_WIDTH)
    ) u_accXor (
        .i_a (r_acc),
        .i_b (rnd),
        .o_y (w_accXorRnd)
    );

    // Controller, share counter, accumulator and share registers; everything holds
    // when no transfer fires, which also covers ena low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_share <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_inXfer) begin
                        r_acc <= i_x;
                        r_cnt <= '0;
                        if (N_SHARES == 1) begin
                            r_share[0] <= i_x;
                            r_state    <= OUT;
                        end else begin
                            r_state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (w_rndXfer) begin
                        for (int j = 0; j < N_SHARES - 1; j++) begin
                            if (r_cnt == CNT_W'(j)) begin
                                r_share[j] <= rnd;
                            end
                        end
                        r_acc <= w_accXorRnd;
                        if (r_cnt == CNT_LAST) begin
                            r_share[N_SHARES-1] <= w_accXorRnd;
                            r_cnt               <= '0;
                            r_state             <= OUT;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (w_outXfer) begin
                        r_share <= '0;
                        r_acc   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bool_share_split.sv
// Directed bench for bool_share_split with a scoreboard of expected share vectors.
module tb_bool_share_split;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic         iVld;
    logic         iRdy;
    logic [31:0]  iX;
    logic         rndVld;
    logic         rndRdy;
    logic [31:0]  rnd;
    logic         oVld;
    logic         oRdy;
    logic [159:0] oZ;
    logic         busy;

    logic         i1Vld;
    logic         i1Rdy;
    logic [31:0]  i1X;
    logic         rnd1Rdy;
    logic         o1Vld;
    logic         o1Rdy;
    logic [31:0]  o1Z;
    logic         busy1;

    int           total = 0;
    int           bad   = 0;
    logic [159:0] sbQ[$];
    logic [31:0]  rndWords [4];
    int           rndIdx;
    int           edgeCnt;
    int           acceptEdge;
    int           riseEdge;
    int           outXfers;
    int           rndRdyDrops;
    bit           stallMode;
    int           stallCnt;
    bit           prevOVld;

    // Free-running clock.
    always #5 clk = ~clk;

    bool_share_split #(
        .K_WIDTH  (32),
        .N_SHARES (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .i_vld    (iVld),
        .i_rdy    (iRdy),
        .i_x      (iX),
        .rnd_vld  (rndVld),
        .rnd_rdy  (rndRdy),
        .rnd      (rnd),
        .o_vld    (oVld),
        .o_rdy    (oRdy),
        .o_z      (oZ),
        .busy     (busy)
    );

    bool_share_split #(
        .K_WIDTH  (32),
        .N_SHARES (1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .i_vld    (i1Vld),
        .i_rdy    (i1Rdy),
        .i_x      (i1X),
        .rnd_vld  (1'b1),
        .rnd_rdy  (rnd1Rdy),
        .rnd      (32'h0),
        .o_vld    (o1Vld),
        .o_rdy    (o1Rdy),
        .o_z      (o1Z),
        .busy     (busy1)
    );

    task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the main DUT: score any output transfer, then advance the edge.
    task automatic applyStimulus();
        bit inX;
        bit rX;
        bit oX;
        inX = iVld && iRdy && ena;
        rX  = rndVld && rndRdy && ena;
        oX  = oVld && oRdy && ena;
        if (busy && !oVld && !rndRdy) rndRdyDrops++;
        if (oX) begin
            if (sbQ.size() == 0) checkOutput("unexpected_out", oZ, 160'd0);
            else checkOutput("o_z_at_xfer", oZ, sbQ.pop_front());
            outXfers++;
        end
        prevOVld = oVld;
        @(posedge clk);
        #1;
        edgeCnt++;
        if (inX) begin
            acceptEdge = edgeCnt;
            iVld = 1'b0;
        end
        if (rX) begin
            rndIdx++;
            rnd = (rndIdx < 4) ? rndWords[rndIdx] : 32'h0;
            if (stallMode && (rndIdx == 1 || rndIdx == 3)) stallCnt = 3;
        end
        if (stallCnt > 0) begin
            rndVld = 1'b0;
            stallCnt--;
        end else begin
            rndVld = 1'b1;
        end
        if (oVld && !prevOVld) riseEdge = edgeCnt;
    endtask

    task automatic startWord(input logic [31:0] x, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        rndWords[0] = w0;
        rndWords[1] = w1;
        rndWords[2] = w2;
        rndWords[3] = w3;
        rndIdx = 0;
        rnd    = w0;
        iX     = x;
        iVld   = 1'b1;
        sbQ.push_back({x ^ w0 ^ w1 ^ w2 ^ w3, w3, w2, w1, w0});
    endtask

    task automatic waitOutXfer(input string tag, input int maxCycles);
        int start;
        start = outXfers;
        for (int c = 0; c < maxCycles && outXfers == start; c++) applyStimulus();
        checkOutput(tag, 160'(outXfers - start), 160'd1);
    endtask

    task automatic waitRndIdx(input string tag, input int n, input int maxCycles);
        for (int c = 0; c < maxCycles && rndIdx < n; c++) applyStimulus();
        checkOutput(tag, 160'(rndIdx >= n), 160'd1);
    endtask

    task automatic waitOVld(input string tag, input int maxCycles);
        for (int c = 0; c < maxCycles && !oVld; c++) applyStimulus();
        checkOutput(tag, 160'(oVld), 160'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        iVld = 1'b0;
        iX = 32'h0;
        rndVld = 1'b1;
        rnd = 32'h0;
        oRdy = 1'b1;
        i1Vld = 1'b0;
        i1X = 32'h0;
        o1Rdy = 1'b0;
        rndIdx = 0;
        edgeCnt = 0;
        acceptEdge = 0;
        riseEdge = 0;
        outXfers = 0;
        rndRdyDrops = 0;
        stallMode = 1'b0;
        stallCnt = 0;
        prevOVld = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_i_rdy", 160'(iRdy), 160'd1);
        checkOutput("rst_o_vld", 160'(oVld), 160'd0);
        checkOutput("rst_o_z", oZ, 160'd0);
        checkOutput("rst_rnd_rdy", 160'(rndRdy), 160'd0);
        checkOutput("rst_busy", 160'(busy), 160'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic split
        $display("[TB] basic split");
        startWord(32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        waitOutXfer("basic_xfer", 20);
        checkOutput("basic_latency", 160'(riseEdge - acceptEdge), 160'd4);
        checkOutput("basic_i_rdy_after", 160'(iRdy), 160'd1);
        checkOutput("basic_o_z_after", oZ, 160'd0);

        // Randomness stalls before the 2nd and 4th word
        $display("[TB] randomness stall");
        stallMode = 1'b1;
        rndRdyDrops = 0;
        startWord(32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        waitOutXfer("stall_xfer", 40);
        checkOutput("stall_latency", 160'(riseEdge - acceptEdge), 160'd10);
        checkOutput("stall_rnd_rdy_drops", 160'(rndRdyDrops), 160'd0);
        stallMode = 1'b0;

        // Output backpressure
        $display("[TB] output backpressure");
        oRdy = 1'b0;
        startWord(32'hCAFEF00D, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678, 32'hFFFFFFFF);
        waitOVld("bp_o_vld", 20);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_o_z_stable", oZ, sbQ[0]);
            checkOutput("bp_i_rdy", 160'(iRdy), 160'd0);
            checkOutput("bp_rnd_rdy", 160'(rndRdy), 160'd0);
            applyStimulus();
        end
        oRdy = 1'b1;
        waitOutXfer("bp_xfer", 5);
        checkOutput("bp_o_z_cleared", oZ, 160'd0);

        // Enable low mid-fill
        $display("[TB] enable freeze");
        startWord(32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        waitRndIdx("ena_reach_fill", 2, 20);
        ena = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("ena_rnd_rdy", 160'(rndRdy), 160'd1);
            checkOutput("ena_busy", 160'(busy), 160'd1);
            applyStimulus();
        end
        ena = 1'b1;
        waitOutXfer("ena_xfer", 20);
        checkOutput("ena_latency", 160'(riseEdge - acceptEdge), 160'd8);

        // Reset mid-fill discards the partial word
        $display("[TB] reset mid-fill");
        startWord(32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        waitRndIdx("rst_reach_fill", 2, 20);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_busy", 160'(busy), 160'd0);
        checkOutput("midrst_o_vld", 160'(oVld), 160'd0);
        checkOutput("midrst_o_z", oZ, 160'd0);
        checkOutput("midrst_i_rdy", 160'(iRdy), 160'd1);
        sbQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        startWord(32'h00000001, 32'h0, 32'h0, 32'h0, 32'h0);
        waitOutXfer("postrst_xfer", 20);
        checkOutput("postrst_latency", 160'(riseEdge - acceptEdge), 160'd4);

        // Single-share instance
        $display("[TB] single share");
        i1X = 32'h12345678;
        i1Vld = 1'b1;
        checkOutput("n1_o_z_idle", 160'(o1Z), 160'd0);
        checkOutput("n1_rnd_rdy_idle", 160'(rnd1Rdy), 160'd0);
        @(posedge clk);
        #1;
        i1Vld = 1'b0;
        checkOutput("n1_o_vld", 160'(o1Vld), 160'd1);
        checkOutput("n1_o_z", 160'(o1Z), 160'h12345678);
        checkOutput("n1_rnd_rdy_out", 160'(rnd1Rdy), 160'd0);
        checkOutput("n1_busy", 160'(busy1), 160'd1);
        o1Rdy = 1'b1;
        @(posedge clk);
        #1;
        o1Rdy = 1'b0;
        checkOutput("n1_o_z_after", 160'(o1Z), 160'd0);
        checkOutput("n1_i_rdy_after", 160'(i1Rdy), 160'd1);

        checkOutput("sb_drained", 160'(sbQ.size()), 160'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
